// File: rtl/exec_datapath.sv
// rtl/exec_datapath.sv - decode, ALU, next-PC and 256x8 data memory of the 8-bit CPU
// Optional shifter (sll/srl on opcodes 0110/0111) is built only when ALU_SHIFT_EN is defined.
module exec_datapath #(
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [7:0] instr,
    input  logic [7:0] pc,
    input  logic [7:0] rd_data0,
    input  logic [7:0] rd_data1,
    input  logic [7:0] off_data,
    output logic [1:0] reg_addr_0,
    output logic [1:0] reg_addr_1,
    output logic [1:0] reg_addr_w,
    output logic       reg_w_en,
    output logic [7:0] wb_data,
    output logic [7:0] next_pc,
    output logic       jump,
    output logic       mem_w_en,
    output logic       mem_r_en,
    output logic       overflow,
    output logic       ovf_sticky
);

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
`ifdef ALU_SHIFT_EN
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
`endif
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_JAL = 4'b1001;
    localparam logic [3:0] OP_LW  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1011;
    localparam logic [3:0] OP_BEQ = 4'b1100;
    localparam logic [3:0] OP_BNE = 4'b1101;
    localparam logic [3:0] OP_J   = 4'b1110;
    localparam logic [3:0] OP_JR  = 4'b1111;

    logic [3:0] opcode;
    logic [1:0] field_a;
    logic [1:0] field_b;
    logic [7:0] pc_inc;
    logic [7:0] imm_sext;
    logic [7:0] sum;
    logic [7:0] diff;
    logic       add_ovf;
    logic       sub_ovf;

    logic [7:0] mem_q [MEM_DEPTH];
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic       ovf_sticky_q;
    logic       ovf_sticky_d;

    assign opcode   = instr[7:4];
    assign field_a  = instr[3:2];
    assign field_b  = instr[1:0];
    assign pc_inc   = pc + 8'd1;
    assign imm_sext = {{4{instr[3]}}, instr[3:0]};

    assign sum     = rd_data0 + rd_data1;
    assign diff    = rd_data0 - rd_data1;
    assign add_ovf = (rd_data0[7] == rd_data1[7]) && (sum[7] != rd_data0[7]);
    assign sub_ovf = (rd_data0[7] != rd_data1[7]) && (diff[7] != rd_data0[7]);

    // jal pushes the return address at the stack pointer (rd0); lw/sw address through rd1
    assign mem_addr  = (opcode == OP_JAL) ? rd_data0 : rd_data1;
    assign mem_wdata = (opcode == OP_JAL) ? pc_inc : rd_data0;
    assign mem_rdata = mem_q[mem_addr];

    always_comb begin
        reg_addr_0 = field_a;
        reg_addr_1 = field_b;
        reg_addr_w = field_a;
        reg_w_en   = 1'b0;
        wb_data    = 8'h00;
        next_pc    = pc_inc;
        jump       = 1'b0;
        mem_w_en   = 1'b0;
        mem_r_en   = 1'b0;
        overflow   = 1'b0;
        case (opcode)
            OP_ADD: begin
                reg_w_en = 1'b1;
                wb_data  = sum;
                overflow = add_ovf;
            end
            OP_SUB: begin
                reg_w_en = 1'b1;
                wb_data  = diff;
                overflow = sub_ovf;
            end
            OP_AND: begin
                reg_w_en = 1'b1;
                wb_data  = rd_data0 & rd_data1;
            end
            OP_OR: begin
                reg_w_en = 1'b1;
                wb_data  = rd_data0 | rd_data1;
            end
            OP_XOR: begin
                reg_w_en = 1'b1;
                wb_data  = rd_data0 ^ rd_data1;
            end
`ifdef ALU_SHIFT_EN
            OP_SLL: begin
                reg_w_en = 1'b1;
                wb_data  = rd_data0 << rd_data1[2:0];
            end
            OP_SRL: begin
                reg_w_en = 1'b1;
                wb_data  = rd_data0 >> rd_data1[2:0];
            end
`endif
            OP_SLT: begin
                reg_w_en = 1'b1;
                wb_data  = {7'd0, ($signed(rd_data0) < $signed(rd_data1))};
            end
            OP_JAL: begin
                reg_addr_0 = 2'd3;
                reg_addr_w = 2'd3;
                reg_w_en   = 1'b1;
                wb_data    = rd_data0 - 8'd1;
                mem_w_en   = 1'b1;
                jump       = 1'b1;
                next_pc    = pc_inc + imm_sext;
            end
            OP_LW: begin
                reg_w_en = 1'b1;
                mem_r_en = 1'b1;
                wb_data  = mem_rdata;
            end
            OP_SW: begin
                mem_w_en = 1'b1;
            end
            OP_BEQ: begin
                jump = (rd_data0 == rd_data1);
                if (jump) next_pc = pc_inc + off_data;
            end
            OP_BNE: begin
                jump = (rd_data0 != rd_data1);
                if (jump) next_pc = pc_inc + off_data;
            end
            OP_J: begin
                jump    = 1'b1;
                next_pc = pc_inc + imm_sext;
            end
            OP_JR: begin
                jump    = 1'b1;
                next_pc = rd_data0;
            end
            default: begin
            end
        endcase
    end

    // Reset clears every word so a program always starts from a known memory image
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (step && mem_w_en) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign ovf_sticky_d = ovf_sticky_q | (step & overflow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_exec_datapath.sv
// tb/tb_exec_datapath.sv - scoreboard bench for exec_datapath with directed vectors
module tb_exec_datapath;

    logic       clk;
    logic       rst_n;
    logic       step;
    logic [7:0] instr;
    logic [7:0] pc;
    logic [7:0] rd_data0;
    logic [7:0] rd_data1;
    logic [7:0] off_data;
    logic [1:0] reg_addr_0;
    logic [1:0] reg_addr_1;
    logic [1:0] reg_addr_w;
    logic       reg_w_en;
    logic [7:0] wb_data;
    logic [7:0] next_pc;
    logic       jump;
    logic       mem_w_en;
    logic       mem_r_en;
    logic       overflow;
    logic       ovf_sticky;

    exec_datapath #(.MEM_DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step),
        .instr      (instr),
        .pc         (pc),
        .rd_data0   (rd_data0),
        .rd_data1   (rd_data1),
        .off_data   (off_data),
        .reg_addr_0 (reg_addr_0),
        .reg_addr_1 (reg_addr_1),
        .reg_addr_w (reg_addr_w),
        .reg_w_en   (reg_w_en),
        .wb_data    (wb_data),
        .next_pc    (next_pc),
        .jump       (jump),
        .mem_w_en   (mem_w_en),
        .mem_r_en   (mem_r_en),
        .overflow   (overflow),
        .ovf_sticky (ovf_sticky)
    );

    typedef struct {
        string      nm;
        logic [1:0] ra0;
        logic [1:0] ra1;
        logic [1:0] raw;
        logic       rwe;
        logic [7:0] wb;
        logic [7:0] npc;
        logic       jmp;
        logic       ovf;
        logic       stk;
        logic       mwe;
        logic       mre;
    } exp_t;

    exp_t sb_q[$];
    logic chk_req;
    int   checks;
    int   errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string nm, input string f, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from the commit edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_req) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow actual=empty required=entry");
                end else begin
                    e = sb_q.pop_front();
                    cmp(e.nm, "reg_addr_0", {6'd0, reg_addr_0}, {6'd0, e.ra0});
                    cmp(e.nm, "reg_addr_1", {6'd0, reg_addr_1}, {6'd0, e.ra1});
                    cmp(e.nm, "reg_addr_w", {6'd0, reg_addr_w}, {6'd0, e.raw});
                    cmp(e.nm, "reg_w_en",   {7'd0, reg_w_en},   {7'd0, e.rwe});
                    cmp(e.nm, "wb_data",    wb_data,            e.wb);
                    cmp(e.nm, "next_pc",    next_pc,            e.npc);
                    cmp(e.nm, "jump",       {7'd0, jump},       {7'd0, e.jmp});
                    cmp(e.nm, "overflow",   {7'd0, overflow},   {7'd0, e.ovf});
                    cmp(e.nm, "ovf_sticky", {7'd0, ovf_sticky}, {7'd0, e.stk});
                    cmp(e.nm, "mem_w_en",   {7'd0, mem_w_en},   {7'd0, e.mwe});
                    cmp(e.nm, "mem_r_en",   {7'd0, mem_r_en},   {7'd0, e.mre});
                end
            end
        end
    end

    task automatic drv(input logic [7:0] i, input logic [7:0] p, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] o, input logic st);
        instr    = i;
        pc       = p;
        rd_data0 = a;
        rd_data1 = b;
        off_data = o;
        step     = st;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] ra0, input logic [1:0] ra1,
                              input logic [1:0] raw, input logic rwe, input logic [7:0] wb,
                              input logic [7:0] npc, input logic jmp, input logic ovf,
                              input logic stk, input logic mwe, input logic mre);
        exp_t e;
        e.nm = nm; e.ra0 = ra0; e.ra1 = ra1; e.raw = raw; e.rwe = rwe; e.wb = wb;
        e.npc = npc; e.jmp = jmp; e.ovf = ovf; e.stk = stk; e.mwe = mwe; e.mre = mre;
        sb_q.push_back(e);
        chk_req = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_req = 1'b0;
        step    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        chk_req = 1'b0;
        rst_n   = 1'b1;
        drv(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        // store attempted while in reset must be dropped
        drv(8'hB1, 8'h00, 8'h77, 8'h05, 8'h00, 1'b1);
        expect_out("rst_sw", 2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;

        drv(8'hA1, 8'h00, 8'h00, 8'h05, 8'h00, 1'b0);
        expect_out("rst_lw",    2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        drv(8'h11, 8'h00, 8'h7F, 8'h01, 8'h00, 1'b1);
        expect_out("add_ovf",   2'd0, 2'd1, 2'd0, 1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drv(8'h21, 8'h00, 8'h05, 8'h03, 8'h00, 1'b1);
        expect_out("sub_keep",  2'd0, 2'd1, 2'd0, 1'b1, 8'h02, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'h21, 8'h00, 8'h80, 8'h01, 8'h00, 1'b0);
        expect_out("sub_ovf",   2'd0, 2'd1, 2'd0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        drv(8'hB1, 8'h00, 8'h3C, 8'h20, 8'h00, 1'b1);
        expect_out("sw_20",     2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
        drv(8'hA1, 8'h00, 8'h00, 8'h20, 8'h00, 1'b0);
        expect_out("lw_20",     2'd0, 2'd1, 2'd0, 1'b1, 8'h3C, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        drv(8'hB1, 8'h00, 8'h99, 8'h21, 8'h00, 1'b0);
        expect_out("sw_nostep", 2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
        drv(8'hA1, 8'h00, 8'h00, 8'h21, 8'h00, 1'b0);
        expect_out("lw_21",     2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        drv(8'hC1, 8'h10, 8'h07, 8'h07, 8'h04, 1'b0);
        expect_out("beq_t",     2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'hC1, 8'h10, 8'h07, 8'h08, 8'h04, 1'b0);
        expect_out("beq_n",     2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'hD1, 8'h10, 8'h07, 8'h07, 8'h04, 1'b0);
        expect_out("bne_n",     2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'hD1, 8'h10, 8'h07, 8'h08, 8'h04, 1'b0);
        expect_out("bne_t",     2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'hC1, 8'hFF, 8'h07, 8'h08, 8'h04, 1'b0);
        expect_out("beq_wrap",  2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'h9E, 8'h20, 8'hFF, 8'h00, 8'h00, 1'b1);
        expect_out("jal",       2'd3, 2'd2, 2'd3, 1'b1, 8'hFE, 8'h1F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();
        drv(8'hA1, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0);
        expect_out("lw_ff",     2'd0, 2'd1, 2'd0, 1'b1, 8'h21, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        drv(8'hF8, 8'h33, 8'h40, 8'h00, 8'h00, 1'b0);
        expect_out("jr",        2'd2, 2'd0, 2'd2, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'hE3, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_out("j_wrap",    2'd0, 2'd3, 2'd0, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'h31, 8'h00, 8'hF0, 8'h3C, 8'h00, 1'b0);
        expect_out("and",       2'd0, 2'd1, 2'd0, 1'b1, 8'h30, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'h41, 8'h00, 8'hF0, 8'h3C, 8'h00, 1'b0);
        expect_out("or",        2'd0, 2'd1, 2'd0, 1'b1, 8'hFC, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'h51, 8'h00, 8'hF0, 8'h3C, 8'h00, 1'b0);
        expect_out("xor",       2'd0, 2'd1, 2'd0, 1'b1, 8'hCC, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'h81, 8'h00, 8'h80, 8'h01, 8'h00, 1'b0);
        expect_out("slt_t",     2'd0, 2'd1, 2'd0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'h81, 8'h00, 8'h01, 8'h80, 8'h00, 1'b0);
        expect_out("slt_f",     2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
`ifdef ALU_SHIFT_EN
        drv(8'h61, 8'h00, 8'h81, 8'h09, 8'h00, 1'b0);
        expect_out("sll",       2'd0, 2'd1, 2'd0, 1'b1, 8'h02, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'h71, 8'h00, 8'h81, 8'h0A, 8'h00, 1'b0);
        expect_out("srl",       2'd0, 2'd1, 2'd0, 1'b1, 8'h20, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
`else
        drv(8'h61, 8'h00, 8'h81, 8'h09, 8'h00, 1'b0);
        expect_out("sll_off",   2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drv(8'h71, 8'h00, 8'h81, 8'h0A, 8'h00, 1'b0);
        expect_out("srl_off",   2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
`endif
        drv(8'h00, 8'h05, 8'hFF, 8'hFF, 8'h00, 1'b1);
        expect_out("nop",       2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h06, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();

        // reset pulled low mid-instruction and held across the commit edge
        drv(8'hB1, 8'h00, 8'h55, 8'h30, 8'h00, 1'b1);
        expect_out("rst_mid",   2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drv(8'hA1, 8'h00, 8'h00, 8'h30, 8'h00, 1'b0);
        expect_out("lw_30",     2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        drv(8'hA1, 8'h00, 8'h00, 8'h20, 8'h00, 1'b0);
        expect_out("lw_20_clr", 2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_datapath.md
Name: exec_datapath

Overview:
- Decode, ALU and data-memory block of the 8-bit, 4-register CPU.
- Takes the current instruction, PC and register-file read data, and produces:
  - register-file addresses and write-back data/enable;
  - the next PC.
- Owns a 256x8 data memory.
- The register file, PC register and instruction memory live outside this block.

Parameters:
- MEM_DEPTH, 256, data-memory words; address is 8 bits, so only 256 is legal.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- step, input, 1, commit strobe; memory write and sticky flag update only on a clk edge with step=1.
- instr, input, 8, instruction: opcode [7:4], field A [3:2], field B [1:0].
- pc, input, 8, address of instr.
- rd_data0, input, 8, register-file contents at reg_addr_0.
- rd_data1, input, 8, register-file contents at reg_addr_1.
- off_data, input, 8, contents of r0 (branch offset).
- reg_addr_0, output, 2, source 0 address.
- reg_addr_1, output, 2, source 1 address.
- reg_addr_w, output, 2, destination address.
- reg_w_en, output, 1, register write enable.
- wb_data, output, 8, write-back data.
- next_pc, output, 8, next PC.
- jump, output, 1, PC redirect taken.
- mem_w_en, output, 1, memory write this instruction.
- mem_r_en, output, 1, memory read this instruction.
- overflow, output, 1, combinational signed overflow for add/sub.
- ovf_sticky, output, 1, registered sticky overflow.

Behaviour:
- Outputs other than ovf_sticky are purely combinational from instr/pc/rd_data/off_data/memory; zero latency.
- Default decode:
  - reg_addr_0 = A, reg_addr_1 = B, reg_addr_w = A.
  - jump = 0, next_pc = pc+1 (mod 256).
- Opcodes:
  - 0000 nop: no enables.
  - 0001 add: wb = rd0+rd1; overflow = signed overflow.
  - 0010 sub: wb = rd0-rd1; overflow = signed overflow.
  - 0011 and, 0100 or, 0101 xor: wb = rd0 op rd1.
  - 0110 sll: wb = rd0 << rd1[2:0].
  - 0111 srl: wb = rd0 >> rd1[2:0] (logical).
  - 1000 slt: wb = (signed rd0 < signed rd1) ? 1 : 0.
  - 1001 jal:
    - reg_addr_0 = 3, reg_addr_w = 3; mem_w_en.
    - mem[rd0] <= pc+1; wb = rd0-1 (stack grows down, wraps 0x00 -> 0xFF).
    - jump = 1; next_pc = pc+1+sext(instr[3:0]).
  - 1010 lw: mem_r_en; wb = mem[rd1].
  - 1011 sw: mem_w_en; mem[rd1] <= rd0; no register write.
  - 1100 beq: jump = (rd0 == rd1); if taken, next_pc = pc+1+off_data.
  - 1101 bne: jump = (rd0 != rd1); same target.
  - 1110 j: jump = 1; next_pc = pc+1+sext(instr[3:0]).
  - 1111 jr: jump = 1; next_pc = rd0.
- reg_w_en = 1 for 0001-1001 and 1010; 0 otherwise.
- wb_data for non-writing opcodes = 8'h00. overflow = 0 for all opcodes other than add/sub.
- All PC and address arithmetic is modulo 256.
- Memory read is asynchronous. Write occurs at posedge clk when step & mem_w_en & rst_n.
- Read and write of the same address in one instruction returns old data.
- ovf_sticky:
  - set at posedge clk when step & overflow;
  - holds otherwise;
  - cleared only by reset.
- Reset (rst_n=0, asynchronous):
  - ovf_sticky = 0 and every memory word = 8'h00 immediately.
  - Writes are suppressed while reset is asserted.
  - Combinational outputs remain valid during reset.
- Reset asserted mid-instruction: the pending write is dropped.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined: opcodes 0110/0111 perform sll/srl as above.
- Undefined: 0110/0111 decode as nop (reg_w_en=0, wb_data=0, next_pc=pc+1) and no shifter is synthesized.

Test Plan:
- Reset: assert rst_n=0 with no clock edge -> ovf_sticky=0. After release, lw (instr=8'hA1) of any address with rd1=8'h05 -> wb_data=8'h00.
- Add overflow: instr=8'h11, rd0=8'h7F, rd1=8'h01 ->
  - wb_data=8'h80, overflow=1, reg_addr_w=0;
  - with step=1, after one edge ovf_sticky=1;
  - a following sub 8'h05-8'h03 keeps ovf_sticky=1.
- Store/load: sw instr=8'hB1, rd0=8'h3C, rd1=8'h20, step=1, one edge; then lw instr=8'hA1, rd1=8'h20 -> wb_data=8'h3C, reg_w_en=1. With step=0 the write does not happen.
- Branches: beq, pc=8'h10, rd0=rd1=8'h07, off_data=8'h04 -> jump=1, next_pc=8'h15. Same with rd1=8'h08 -> jump=0, next_pc=8'h11. bne gives the inverse. pc=8'hFF not taken -> next_pc=8'h00.
- jal: instr=8'h9E (imm=-2), pc=8'h20, rd0 (r3)=8'hFF, step=1 ->
  - reg_addr_0=3, reg_addr_w=3, wb_data=8'hFE, next_pc=8'h1F;
  - afterwards mem[8'hFF]=8'h21.
- jr: instr=8'hF8, rd0=8'h40 -> next_pc=8'h40. Shift: instr=8'h61, rd0=8'h81, rd1=8'h09 -> wb_data=8'h02 (shift by 1) when ALU_SHIFT_EN is defined; reg_w_en=0 when it is undefined.
